// File: rtl/reg_file_main.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_main
//  Description : 16 x 16-bit general-purpose register file for the 16-bit
//                single-cycle RISC core. It has two combinational read ports
//                (Ra/Rb) and one synchronous write port (Rd/R_Write/Gwe).
//                R0 is an ordinary writable register. Reads do not bypass
//                same-cycle writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file_main (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  Rs,
    input  logic [3:0]  Rt,
    input  logic [3:0]  Rd,
    input  logic [15:0] R_Write,
    input  logic        Gwe,
    output logic [15:0] Ra,
    output logic [15:0] Rb
);

    localparam int c_NUM_REGS = 16;

    logic [15:0] r_regs [c_NUM_REGS];

    // Register storage. Reset clears every entry and takes priority over a
    // write in the same cycle. Otherwise Gwe loads R_Write into entry Rd.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_regs[i] <= 16'h0000;
            end
        end else if (Gwe) begin
            r_regs[Rd] <= R_Write;
        end
    end

    // Read ports are purely combinational from the current storage state.
    // A write shows up on a read port only after the capturing edge.
    always_comb begin
        Ra = r_regs[Rs];
        Rb = r_regs[Rt];
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_main.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file_main
//  Description : Self-checking bench for reg_file_main. It combines a vector
//                table, hand-written corner sequences, and randomized
//                traffic. All traffic is checked against an array-based
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_main;

    logic        clk;
    logic        rst;
    logic [3:0]  Rs;
    logic [3:0]  Rt;
    logic [3:0]  Rd;
    logic [15:0] R_Write;
    logic        Gwe;
    logic [15:0] Ra;
    logic [15:0] Rb;

    int n_tests;
    int n_fail;

    // Reference model: the architectural register contents.
    logic [15:0] mdl [16];

    reg_file_main dut (
        .clk     (clk),
        .rst     (rst),
        .Rs      (Rs),
        .Rt      (Rt),
        .Rd      (Rd),
        .R_Write (R_Write),
        .Gwe     (Gwe),
        .Ra      (Ra),
        .Rb      (Rb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        rst;
        logic        gwe;
        logic [3:0]  rd;
        logic [15:0] wdata;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic [15:0] exp_ra;
        logic [15:0] exp_rb;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // One rising edge: the model applies the rules to the inputs present
    // at the edge. Outputs are then sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 16; i++) mdl[i] = 16'h0000;
        end else if (Gwe) begin
            mdl[Rd] = R_Write;
        end
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0; Gwe = 1'b0; Rd = '0; R_Write = '0; Rs = '0; Rt = '0;
        for (int i = 0; i < 16; i++) mdl[i] = 16'h0000;

        // Vector table. Each entry drives one edge, then reads Rs/Rt.
        vecs[0] = '{1'b1, 1'b1, 4'd7,  16'hFFFF, 4'd7,  4'd0,  16'h0000, 16'h0000};
        vecs[1] = '{1'b0, 1'b1, 4'd15, 16'hAAAA, 4'd15, 4'd0,  16'hAAAA, 16'h0000};
        vecs[2] = '{1'b0, 1'b0, 4'd3,  16'h1234, 4'd3,  4'd15, 16'h0000, 16'hAAAA};
        vecs[3] = '{1'b0, 1'b1, 4'd0,  16'h5A5A, 4'd0,  4'd0,  16'h5A5A, 16'h5A5A};
        vecs[4] = '{1'b0, 1'b1, 4'd3,  16'h1234, 4'd3,  4'd0,  16'h1234, 16'h5A5A};
        vecs[5] = '{1'b1, 1'b0, 4'd3,  16'h9999, 4'd3,  4'd15, 16'h0000, 16'h0000};
        vecs[6] = '{1'b0, 1'b1, 4'd15, 16'hFFFF, 4'd15, 4'd15, 16'hFFFF, 16'hFFFF};

        // Reset, then read all 16 indices through both ports.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            Rs = 4'(i); Rt = 4'(15 - i);
            #1;
            chk($sformatf("reset_ra[%0d]", i), Ra, 16'h0000);
            chk($sformatf("reset_rb[%0d]", 15 - i), Rb, 16'h0000);
        end

        // Table-driven vectors.
        for (int v = 0; v < 7; v++) begin
            rst = vecs[v].rst; Gwe = vecs[v].gwe; Rd = vecs[v].rd;
            R_Write = vecs[v].wdata;
            tick();
            rst = 1'b0; Gwe = 1'b0;
            Rs = vecs[v].rs; Rt = vecs[v].rt;
            #1;
            chk($sformatf("vec%0d_ra", v), Ra, vecs[v].exp_ra);
            chk($sformatf("vec%0d_rb", v), Rb, vecs[v].exp_rb);
        end

        // Fill every register including R0, then read mirrored pairs.
        for (int i = 0; i < 16; i++) begin
            Gwe = 1'b1; Rd = 4'(i); R_Write = 16'h1000 + 16'(i);
            tick();
        end
        Gwe = 1'b0;
        for (int i = 0; i < 16; i++) begin
            Rs = 4'(i); Rt = 4'(15 - i);
            #1;
            chk($sformatf("dual_ra[%0d]", i), Ra, 16'h1000 + 16'(i));
            chk($sformatf("dual_rb[%0d]", 15 - i), Rb, 16'h100F - 16'(i));
            Rt = 4'(i);
            #1;
            chk($sformatf("same_idx[%0d]", i), Rb, Ra);
        end

        // Read during write: the old value shows before the edge and the new value after it.
        Gwe = 1'b1; Rd = 4'd5; R_Write = 16'h0005;
        tick();
        Rs = 4'd5; Rd = 4'd5; R_Write = 16'hBEEF; Gwe = 1'b1;
        #1;
        chk("rdw_before", Ra, 16'h0005);
        tick();
        Gwe = 1'b0;
        chk("rdw_after", Ra, 16'hBEEF);

        // A mid-cycle glitch on Gwe has no effect.
        Rd = 4'd6; R_Write = 16'hDEAD; Rs = 4'd6;
        #2 Gwe = 1'b1;
        #2 Gwe = 1'b0;
        tick();
        chk("gwe_glitch", Ra, 16'h1006);

        // Reset priority over a same-edge write. All registers must read zero.
        rst = 1'b1; Gwe = 1'b1; Rd = 4'd7; R_Write = 16'hFFFF;
        tick();
        rst = 1'b0; Gwe = 1'b0;
        for (int i = 0; i < 16; i++) begin
            Rs = 4'(i); Rt = 4'(i);
            #1;
            chk($sformatf("rst_prio[%0d]", i), Ra, 16'h0000);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            rst     = ($urandom_range(0, 31) == 0);
            Gwe     = 1'($urandom);
            Rd      = 4'($urandom);
            R_Write = 16'($urandom);
            Rs      = 4'($urandom);
            Rt      = (n % 5 == 0) ? Rd : 4'($urandom);
            #1;
            chk("rand_pre_ra", Ra, mdl[Rs]);
            tick();
            rst = 1'b0; Gwe = 1'b0;
            chk("rand_ra", Ra, mdl[Rs]);
            chk("rand_rb", Rb, mdl[Rt]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
